// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//
// Contents:
//   OVERSAMPLE       baud ticks per bit (16)
//   MidIdx / EndIdx  tick-counter values for mid start bit and bit end
//   uart_parity_t    parity mode as it appears on the Parity input
//   uart_rx_state_t  receiver FSM states
//   parity_enabled() true for the modes that carry a parity bit on the line

package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  // Mid start bit is sampled at tick 7; later bits are sampled a full bit
  // (16 ticks) after that point, i.e. when the counter reaches 15.
  localparam logic [3:0] MidIdx = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] EndIdx = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    RSVD = 2'b11
  } uart_parity_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_rx_state_t;

  // RSVD behaves like NONE: no parity bit is expected on the line.
  function automatic logic parity_enabled(input uart_parity_t mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//
// Both stages reset to ResetVal so the output matches the idle level of the
// line being synchronized (1 for UART rxd/CTS). Output lags input by 2 Clk.
//
// Ports:
//   Clk  in   system clock
//   Rst  in   synchronous, active-high reset
//   d    in   asynchronous input
//   q    out  synchronized output

module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with valid/ready output.
//
// Consumes baud_tick pulses (16 per bit) from the baud generator, validates
// the start bit at its midpoint, samples data/parity/stop bits at their
// midpoints and delivers each good word on m_tdata/m_tvalid. Framing,
// parity and overrun problems are reported as single-cycle pulses.
//
// Ports:
//   Clk          in   system clock
//   Rst          in   synchronous, active-high reset
//   En           in   receiver enable; low aborts the frame in progress
//   baud_tick    in   one-cycle pulse at 16x the bit rate
//   rxd          in   asynchronous serial input, idle high
//   Parity       in   00 none, 01 even, 10 odd, 11 none; latched at start
//   m_tdata      out  received word
//   m_tvalid     out  m_tdata holds an unconsumed word
//   m_tready     in   consumer accepts the word
//   busy         out  FSM is not idle
//   frame_err    out  pulse: stop bit sampled low
//   parity_err   out  pulse: parity mismatch on a delivered frame
//   overrun_err  out  pulse: word completed while the output was still full
//
// DATA_W must lie in 5..8.

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              baud_tick,
  input  logic              rxd,
  input  logic [1:0]        Parity,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);

  localparam logic [2:0] LastIdx = 3'(DATA_W - 1);

  logic rxs;

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync_rxd (
    .Clk(Clk),
    .Rst(Rst),
    .d  (rxd),
    .q  (rxs)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  uart_rx_state_t    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  uart_parity_t      par_mode_q, par_mode_d;
  logic              par_err_q, par_err_d;
  logic              busy_q, busy_d;

  // Single-cycle request from the FSM to hand the shift register to the output.
  logic deliver;
  logic frame_err_d;
  logic parity_err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_mode_d   = par_mode_q;
    par_err_d    = par_err_q;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    if (!En) begin
      state_d   = StIdle;
      cnt_d     = '0;
      bit_idx_d = '0;
      par_err_d = 1'b0;
    end else if (baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d    = StStart;
            cnt_d      = 4'd1;
            par_mode_d = uart_parity_t'(Parity);
            par_err_d  = 1'b0;
          end
        end

        StStart: begin
          if (cnt_q == MidIdx) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_d   = rxs ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        StData: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == EndIdx) begin
            // LSB arrives first, so shift in from the top.
            shift_d = {rxs, shift_q[DATA_W-1:1]};
            if (bit_idx_q == LastIdx) begin
              state_d = parity_enabled(par_mode_q) ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end

        StParity: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == EndIdx) begin
            // Even mode wants XOR(data, parity) = 0, odd mode wants 1.
            if (((^shift_q) ^ rxs) != (par_mode_q == ODD)) begin
              par_err_d = 1'b1;
            end
            state_d = StStop;
          end
        end

        StStop: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == EndIdx) begin
            cnt_d = '0;
            if (rxs) begin
              deliver      = 1'b1;
              parity_err_d = par_err_q;
              state_d      = StIdle;
            end else begin
              // Bad stop bit: the word is dropped and parity is moot.
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end
          end
        end

        StBreak: begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_mode_q <= NONE;
      par_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_err_q  <= par_err_d;
      busy_q     <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              frame_err_q, parity_err_q;
  logic              overrun_err_q, overrun_err_d;

  always_comb begin
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q;
    overrun_err_d = 1'b0;

    if (deliver) begin
      // A word being accepted this cycle frees the slot for the new one.
      if (!m_tvalid_q || m_tready) begin
        m_tdata_d  = shift_q;
        m_tvalid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign m_tdata     = m_tdata_q;
  assign m_tvalid    = m_tvalid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: reset state, table of hand-computed
// frames, hand-written corner sequences, then random frames checked against
// a frame-level reference model.

module tb_uart_rx;

  localparam int unsigned DW     = 8;
  localparam int unsigned BitClk = 64;  // 16 ticks x 4 Clk per tick

  logic          Clk       = 1'b0;
  logic          Rst       = 1'b1;
  logic          En        = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rxd       = 1'b1;
  logic [1:0]    Parity    = 2'b00;
  logic          m_tready  = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .DATA_W(DW)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .En         (En),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .Parity     (Parity),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err)
  );

  always #5 Clk = ~Clk;

  logic [1:0] div_q = 2'd0;
  always @(posedge Clk) begin
    div_q     <= div_q + 2'd1;
    baud_tick <= (div_q == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // Output monitor (samples on the falling edge)
  // ---------------------------------------------------------------------------
  logic          mon_clr = 1'b1;
  int            n_words, n_perr, n_perr_w, n_ferr, n_ovr, busy_cycles;
  logic [DW-1:0] last_word;
  logic          valid_prev = 1'b0;
  logic          ready_prev = 1'b0;

  always @(negedge Clk) begin
    if (mon_clr) begin
      n_words     <= 0;
      n_perr      <= 0;
      n_perr_w    <= 0;
      n_ferr      <= 0;
      n_ovr       <= 0;
      busy_cycles <= 0;
      last_word   <= '0;
    end else begin
      if (m_tvalid && (!valid_prev || ready_prev)) begin
        n_words   <= n_words + 1;
        last_word <= m_tdata;
        if (parity_err) n_perr_w <= n_perr_w + 1;
      end
      if (parity_err)  n_perr      <= n_perr + 1;
      if (frame_err)   n_ferr      <= n_ferr + 1;
      if (overrun_err) n_ovr       <= n_ovr + 1;
      if (busy)        busy_cycles <= busy_cycles + 1;
    end
    valid_prev <= m_tvalid;
    ready_prev <= m_tready;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clear_mon();
    step(1);
    mon_clr = 1'b1;
    step(1);
    mon_clr = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    step(BitClk);
  endtask

  // Full frame, then two idle bit-times so all results have settled.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] mode,
                            input logic pbit, input logic stop);
    Parity = mode;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(data[i]);
    if (mode == 2'b01 || mode == 2'b10) send_bit(pbit);
    send_bit(stop);
    if (!stop) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Hand-computed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [7:0] data;
    logic [1:0] mode;
    logic       pbit;
    logic       stop;
    int         exp_words;
    logic [7:0] exp_word;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  int   exp_words, exp_perr, exp_ferr;
  logic [7:0] rdata;
  logic [1:0] rmode;
  logic       rpbit, rstop;

  initial begin
    vecs[0] = '{"8n1_55",      8'h55, 2'b00, 1'b0, 1'b1, 1, 8'h55, 0, 0};
    vecs[1] = '{"even_07_p0",  8'h07, 2'b01, 1'b0, 1'b1, 1, 8'h07, 1, 0};
    vecs[2] = '{"even_07_p1",  8'h07, 2'b01, 1'b1, 1'b1, 1, 8'h07, 0, 0};
    vecs[3] = '{"odd_07_p0",   8'h07, 2'b10, 1'b0, 1'b1, 1, 8'h07, 0, 0};
    vecs[4] = '{"odd_c3_p0",   8'hC3, 2'b10, 1'b0, 1'b1, 1, 8'hC3, 1, 0};
    vecs[5] = '{"rsvd_80",     8'h80, 2'b11, 1'b0, 1'b1, 1, 8'h80, 0, 0};
    vecs[6] = '{"stop0_5a",    8'h5A, 2'b00, 1'b0, 1'b0, 0, 8'h00, 0, 1};

    // Reset
    step(4);
    chk("rst_tdata", int'(m_tdata), 0);
    chk("rst_tvalid", int'(m_tvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_perr", int'(parity_err), 0);
    chk("rst_ovr", int'(overrun_err), 0);
    Rst = 1'b0;
    En  = 1'b1;
    step(BitClk);

    // Table
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].mode, vecs[i].pbit, vecs[i].stop);
      chk({vecs[i].name, "_words"}, n_words, vecs[i].exp_words);
      if (vecs[i].exp_words == 1) chk({vecs[i].name, "_data"}, int'(last_word),
                                      int'(vecs[i].exp_word));
      chk({vecs[i].name, "_perr"}, n_perr, vecs[i].exp_perr);
      chk({vecs[i].name, "_perr_with_word"}, n_perr_w, vecs[i].exp_perr);
      chk({vecs[i].name, "_ferr"}, n_ferr, vecs[i].exp_ferr);
      chk({vecs[i].name, "_ovr"}, n_ovr, 0);
      if (i == 0) chk_range("8n1_busy_cycles", busy_cycles, 560, 640);
    end

    // Start glitch of 4 ticks
    clear_mon();
    rxd = 1'b0;
    step(16);
    rxd = 1'b1;
    step(2 * BitClk);
    chk("glitch_words", n_words, 0);
    chk("glitch_busy", int'(busy), 0);
    chk_range("glitch_busy_cycles", busy_cycles, 20, 28);

    // Bad stop bit, line held low (break), then a good frame
    clear_mon();
    Parity = 2'b00;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(((8'hA3 >> i) & 8'h01) != 0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("break_busy_held", int'(busy), 1);
    chk("break_ferr", n_ferr, 1);
    chk("break_words", n_words, 0);
    send_bit(1'b1);
    chk("break_exit_busy", int'(busy), 0);
    clear_mon();
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1);
    chk("after_break_words", n_words, 1);
    chk("after_break_data", int'(last_word), 8'h3C);

    // Overrun with the consumer stalled
    clear_mon();
    m_tready = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1);
    chk("ovr_tvalid", int'(m_tvalid), 1);
    chk("ovr_tdata", int'(m_tdata), 8'h11);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_words", n_words, 1);
    m_tready = 1'b1;
    step(1);
    chk("ovr_drain_tvalid", int'(m_tvalid), 0);

    // Reset in the middle of data bit 4
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'hAB >> i) & 8'h01) != 0);
    rxd = 1'b0;
    step(BitClk / 2);
    Rst = 1'b1;
    rxd = 1'b1;
    step(1);
    Rst = 1'b0;
    chk("midrst_tdata", int'(m_tdata), 0);
    chk("midrst_tvalid", int'(m_tvalid), 0);
    chk("midrst_busy", int'(busy), 0);
    step(2 * BitClk);
    chk("midrst_words", n_words, 0);
    send_frame(8'hF0, 2'b00, 1'b0, 1'b1);
    chk("midrst_next_words", n_words, 1);
    chk("midrst_next_data", int'(last_word), 8'hF0);

    // Enable dropped mid-frame
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b0);
    En  = 1'b0;
    rxd = 1'b1;
    step(3);
    chk("en_abort_busy", int'(busy), 0);
    En = 1'b1;
    step(2 * BitClk);
    chk("en_abort_words", n_words, 0);
    chk("en_abort_ferr", n_ferr, 0);

    // Random frames against the frame-level model
    for (int n = 0; n < 24; n++) begin
      rdata = 8'($urandom);
      rmode = 2'($urandom_range(0, 3));
      rpbit = 1'($urandom_range(0, 1));
      rstop = ($urandom_range(0, 4) != 0);
      exp_words = rstop ? 1 : 0;
      exp_ferr  = rstop ? 0 : 1;
      exp_perr  = 0;
      if (rstop && (rmode == 2'b01 || rmode == 2'b10)) begin
        // Total ones over data+parity must be even (even mode) or odd (odd mode).
        if ((($countones(rdata) + int'(rpbit)) % 2) != ((rmode == 2'b10) ? 1 : 0)) exp_perr = 1;
      end
      clear_mon();
      send_frame(rdata, rmode, rpbit, rstop);
      chk($sformatf("rnd%0d_words", n), n_words, exp_words);
      if (exp_words == 1) chk($sformatf("rnd%0d_data", n), int'(last_word), int'(rdata));
      chk($sformatf("rnd%0d_perr", n), n_perr, exp_perr);
      chk($sformatf("rnd%0d_ferr", n), n_ferr, exp_ferr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
